// File: rtl/conv_layer_sequencer.sv
// Sequencer for one convolutional layer: fills the shared sample window, starts all channels,
// collects per-channel results and hands the layer output downstream. Optional watchdog: CONV_LAYER_SEQUENCER_TIMEOUT_EN.
//
// state  | meaning
// eFILL  | accepting samples until the window target is reached
// eSTART | one-cycle start pulse to every channel
// eWAIT  | input stream held, collecting channel results
// eOUT   | layer output valid, waiting for downstream yumi
module conv_layer_sequencer #(
    parameter int NUM_CHANNELS   = 4,
    parameter int WORD_SIZE      = 16,
    parameter int OUT_HEIGHT     = 2,
    parameter int FILL_COUNT     = 6,
    parameter int STRIDE         = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                                      clk_i,
    input  logic                                      reset_n_i,
    input  logic                                      flush_i,
    input  logic                                      valid_i,
    input  logic [WORD_SIZE-1:0]                      data_i,
    output logic                                      ready_o,
    output logic                                      shift_en_o,
    output logic [WORD_SIZE-1:0]                      shift_data_o,
    output logic [NUM_CHANNELS-1:0]                   conv_start_o,
    input  logic [NUM_CHANNELS-1:0]                   conv_valid_i,
    output logic [NUM_CHANNELS-1:0]                   conv_yumi_o,
    input  logic [NUM_CHANNELS*OUT_HEIGHT*WORD_SIZE-1:0] conv_data_i,
    output logic                                      valid_o,
    input  logic                                      yumi_i,
    output logic [NUM_CHANNELS*OUT_HEIGHT*WORD_SIZE-1:0] data_o,
    output logic                                      busy_o,
    output logic                                      error_o
);

    localparam int CNT_W = $clog2(FILL_COUNT + 1);
    localparam int CH_W  = OUT_HEIGHT * WORD_SIZE;

    typedef enum logic [1:0] {eFILL, eSTART, eWAIT, eOUT} state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [CNT_W-1:0]        target;
    logic                    first_q, first_d;
    logic [NUM_CHANNELS-1:0] done_q, done_d;
    logic [NUM_CHANNELS-1:0] take;
    logic [NUM_CHANNELS*CH_W-1:0] data_q;
    logic                    accept;
    logic                    timeout;
    logic                    abort;

    // ready is gated by reset so the reset value of state does not leak onto the handshake
    assign ready_o      = reset_n_i && (state_q == eFILL);
    assign accept       = valid_i && ready_o;
    assign shift_en_o   = accept;
    assign shift_data_o = data_i;
    assign conv_start_o = {NUM_CHANNELS{(state_q == eSTART) && !flush_i}};
    assign take         = (state_q == eWAIT) ? (conv_valid_i & ~done_q) : '0;
    assign conv_yumi_o  = take;
    assign valid_o      = (state_q == eOUT);
    assign busy_o       = (state_q == eSTART) || (state_q == eWAIT);
    assign data_o       = data_q;
    assign abort        = flush_i || timeout;
    assign target       = first_q ? CNT_W'(FILL_COUNT) : CNT_W'(STRIDE);

`ifdef CONV_LAYER_SEQUENCER_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] wait_q;
    logic            error_q;

    // down-counter reaches zero on the TIMEOUT_CYCLES-th cycle spent in eWAIT
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wait_q  <= '0;
            error_q <= 1'b0;
        end else begin
            if (state_q == eSTART)
                wait_q <= TO_W'(TIMEOUT_CYCLES - 1);
            else if ((state_q == eWAIT) && (wait_q != '0))
                wait_q <= wait_q - 1'b1;
            if (timeout)
                error_q <= 1'b1;
            else if (flush_i)
                error_q <= 1'b0;
        end
    end

    assign timeout = (state_q == eWAIT) && (wait_q == '0) && !(&(done_q | take));
    assign error_o = error_q;
`else
    localparam int unused_timeout = TIMEOUT_CYCLES;

    assign timeout = 1'b0;
    assign error_o = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= eFILL;
            cnt_q   <= '0;
            first_q <= 1'b1;
            done_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            first_q <= first_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        first_d = first_q;
        done_d  = done_q;
        case (state_q)
            eFILL: begin
                if (accept) begin
                    if (cnt_q + 1'b1 == target) begin
                        cnt_d   = '0;
                        first_d = 1'b0;
                        state_d = eSTART;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            eSTART: state_d = eWAIT;
            eWAIT: begin
                done_d = done_q | take;
                if (&done_d) begin
                    done_d  = '0;
                    state_d = eOUT;
                end
            end
            eOUT: begin
                if (yumi_i)
                    state_d = eFILL;
            end
            default: state_d = eFILL;
        endcase
        if (abort) begin
            state_d = eFILL;
            first_d = 1'b1;
            cnt_d   = '0;
            done_d  = '0;
        end
    end

    // a result consumed during an aborted frame is discarded; data_o keeps the last frame
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            data_q <= '0;
        end else begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                if (take[c] && !abort)
                    data_q[c*CH_W +: CH_W] <= conv_data_i[c*CH_W +: CH_W];
            end
        end
    end

endmodule

// File: tb/tb_conv_layer_sequencer.sv
// Directed bench for conv_layer_sequencer: per-cycle vector table plus hand-written reset/timeout sequences.
module tb_conv_layer_sequencer;

    localparam int N  = 4;
    localparam int WS = 16;
    localparam int OH = 2;
    localparam int DW = N * OH * WS;

    logic          clk_i = 1'b0;
    logic          reset_n_i;
    logic          flush_i;
    logic          valid_i;
    logic [WS-1:0] data_i;
    logic          ready_o;
    logic          shift_en_o;
    logic [WS-1:0] shift_data_o;
    logic [N-1:0]  conv_start_o;
    logic [N-1:0]  conv_valid_i;
    logic [N-1:0]  conv_yumi_o;
    logic [DW-1:0] conv_data_i;
    logic          valid_o;
    logic          yumi_i;
    logic [DW-1:0] data_o;
    logic          busy_o;
    logic          error_o;

    conv_layer_sequencer dut (
        .clk_i(clk_i), .reset_n_i(reset_n_i), .flush_i(flush_i),
        .valid_i(valid_i), .data_i(data_i), .ready_o(ready_o),
        .shift_en_o(shift_en_o), .shift_data_o(shift_data_o),
        .conv_start_o(conv_start_o), .conv_valid_i(conv_valid_i),
        .conv_yumi_o(conv_yumi_o), .conv_data_i(conv_data_i),
        .valid_o(valid_o), .yumi_i(yumi_i), .data_o(data_o),
        .busy_o(busy_o), .error_o(error_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic       vi;
        logic [3:0] cv;
        logic       yi;
        logic       fl;
        logic       e_rdy;
        logic       e_st;
        logic [3:0] e_ym;
        logic       e_vo;
        logic       e_bz;
    } row_t;

    row_t          tbl[$];
    int            checks   = 0;
    int            failures = 0;
    int            kk       = 0;
    logic          exp_err  = 1'b0;
    logic [DW-1:0] exp_data = '0;

    function automatic row_t mk(input logic vi, input logic [3:0] cv, input logic yi, input logic fl,
                                input logic e_rdy, input logic e_st, input logic [3:0] e_ym,
                                input logic e_vo, input logic e_bz);
        row_t r;
        r.vi = vi; r.cv = cv; r.yi = yi; r.fl = fl;
        r.e_rdy = e_rdy; r.e_st = e_st; r.e_ym = e_ym; r.e_vo = e_vo; r.e_bz = e_bz;
        return r;
    endfunction

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s (row %0d): got %h expected %h", name, kk, act, exp);
        end
    endtask

    // drive one cycle of stimulus, compare mid-cycle, then advance past the next rising edge
    task automatic run_row(input row_t r);
        logic [28:0] act;
        logic [28:0] exp;
        logic [DW-1:0] cd;
        valid_i      = r.vi;
        data_i       = WS'((kk + 1) * 256);
        conv_valid_i = r.cv;
        yumi_i       = r.yi;
        flush_i      = r.fl;
        for (int c = 0; c < N; c++)
            for (int w = 0; w < OH; w++)
                cd[c*OH*WS + w*WS +: WS] = {kk[7:0], 4'(c), 4'(w)};
        conv_data_i = cd;
        #3;
        act = {ready_o, shift_en_o, conv_start_o, conv_yumi_o, valid_o, busy_o, error_o, shift_data_o};
        exp = {r.e_rdy, r.vi & r.e_rdy, {4{r.e_st}}, r.e_ym, r.e_vo, r.e_bz, exp_err, data_i};
        check("ctl", DW'(act), DW'(exp));
        check("data_o", data_o, exp_data);
        if (!r.fl)
            for (int c = 0; c < N; c++)
                if (r.e_ym[c]) exp_data[c*OH*WS +: OH*WS] = cd[c*OH*WS +: OH*WS];
        @(posedge clk_i);
        #1;
        kk++;
    endtask

    task automatic fill_rows(input int n);
        for (int i = 0; i < n; i++) run_row(mk(1, 4'h0, 0, 0, 1, 0, 4'h0, 0, 0));
    endtask

    task automatic start_row();
        run_row(mk(0, 4'h0, 0, 0, 0, 1, 4'h0, 0, 1));
    endtask

    initial begin
        reset_n_i = 1'b1; flush_i = 1'b0; valid_i = 1'b0; data_i = '0;
        conv_valid_i = '0; conv_data_i = '0; yumi_i = 1'b0;

        // first frame: 6 samples, all channels finish together 5 cycles after start
        for (int i = 0; i < 6; i++) tbl.push_back(mk(1, 4'h0, 0, 0, 1, 0, 4'h0, 0, 0));
        tbl.push_back(mk(0, 4'h0, 0, 0, 0, 1, 4'h0, 0, 1));
        for (int i = 0; i < 4; i++) tbl.push_back(mk(0, 4'h0, 0, 0, 0, 0, 4'h0, 0, 1));
        tbl.push_back(mk(0, 4'hF, 0, 0, 0, 0, 4'hF, 0, 1));
        tbl.push_back(mk(1, 4'h0, 1, 0, 0, 0, 4'h0, 1, 0));
        // stride frame: 2 samples, staggered channels, output held 4 cycles
        for (int i = 0; i < 2; i++) tbl.push_back(mk(1, 4'h0, 0, 0, 1, 0, 4'h0, 0, 0));
        tbl.push_back(mk(0, 4'h0, 0, 0, 0, 1, 4'h0, 0, 1));
        tbl.push_back(mk(0, 4'h0, 1, 0, 0, 0, 4'h0, 0, 1));
        tbl.push_back(mk(0, 4'h0, 0, 0, 0, 0, 4'h0, 0, 1));
        tbl.push_back(mk(0, 4'h4, 0, 0, 0, 0, 4'h4, 0, 1));
        tbl.push_back(mk(0, 4'h4, 0, 0, 0, 0, 4'h0, 0, 1));
        tbl.push_back(mk(0, 4'h5, 0, 0, 0, 0, 4'h1, 0, 1));
        tbl.push_back(mk(0, 4'h5, 0, 0, 0, 0, 4'h0, 0, 1));
        tbl.push_back(mk(0, 4'h5, 0, 0, 0, 0, 4'h0, 0, 1));
        tbl.push_back(mk(0, 4'hF, 0, 0, 0, 0, 4'hA, 0, 1));
        for (int i = 0; i < 4; i++) tbl.push_back(mk(0, 4'h0, 0, 0, 0, 0, 4'h0, 1, 0));
        tbl.push_back(mk(0, 4'h0, 1, 0, 0, 0, 4'h0, 1, 0));
        // flush in eWAIT with done=0101; ch1 yumi in the flush cycle is still issued
        for (int i = 0; i < 2; i++) tbl.push_back(mk(1, 4'h0, 0, 0, 1, 0, 4'h0, 0, 0));
        tbl.push_back(mk(0, 4'h0, 0, 0, 0, 1, 4'h0, 0, 1));
        tbl.push_back(mk(0, 4'h5, 0, 0, 0, 0, 4'h5, 0, 1));
        tbl.push_back(mk(0, 4'h7, 0, 1, 0, 0, 4'h2, 0, 1));
        for (int i = 0; i < 6; i++) tbl.push_back(mk(1, 4'h0, 0, 0, 1, 0, 4'h0, 0, 0));
        tbl.push_back(mk(0, 4'h0, 0, 0, 0, 1, 4'h0, 0, 1));
        tbl.push_back(mk(0, 4'hF, 0, 0, 0, 0, 4'hF, 0, 1));
        tbl.push_back(mk(0, 4'h0, 1, 0, 0, 0, 4'h0, 1, 0));
        tbl.push_back(mk(0, 4'h0, 0, 0, 1, 0, 4'h0, 0, 0));

        #1 reset_n_i = 1'b0;
        valid_i = 1'b1;
        #2;
        check("reset_outs", DW'({valid_o, conv_start_o, conv_yumi_o, busy_o, error_o, ready_o, shift_en_o}), '0);
        check("reset_data", data_o, '0);
        @(posedge clk_i);
        @(posedge clk_i);
        #1 reset_n_i = 1'b1;

        foreach (tbl[i]) run_row(tbl[i]);

        // asynchronous reset in the middle of eWAIT, then a full 6-sample refill
        fill_rows(2);
        start_row();
        run_row(mk(0, 4'h0, 0, 0, 0, 0, 4'h0, 0, 1));
        conv_valid_i = 4'b0101;
        #1 reset_n_i = 1'b0;
        #1;
        check("async_rst_outs", DW'({valid_o, conv_start_o, conv_yumi_o, busy_o, error_o, ready_o, shift_en_o}), '0);
        check("async_rst_data", data_o, '0);
        exp_data = '0;
        conv_valid_i = '0;
        @(posedge clk_i);
        #1 reset_n_i = 1'b1;
        fill_rows(6);
        start_row();

`ifdef CONV_LAYER_SEQUENCER_TIMEOUT_EN
        // ch3 never answers: error after 64 cycles in eWAIT, sticky until flush
        run_row(mk(0, 4'h7, 0, 0, 0, 0, 4'h7, 0, 1));
        for (int i = 0; i < 63; i++) run_row(mk(0, 4'h7, 0, 0, 0, 0, 4'h0, 0, 1));
        exp_err = 1'b1;
        fill_rows(6);
        start_row();
        run_row(mk(0, 4'h0, 0, 1, 0, 0, 4'h0, 0, 1));
        exp_err = 1'b0;
        run_row(mk(0, 4'h0, 0, 0, 1, 0, 4'h0, 0, 0));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/conv_layer_sequencer.md
Name: conv_layer_sequencer

Overview:
- Control block for one convolutional layer: a bank of NUM_CHANNELS convolution units that share one input shift stream.
- Admits input samples into the shared shift register, issues start to all channels, collects each channel's valid/yumi result, and presents the whole layer output downstream with a valid/yumi handshake.
- Holds the input stream while the channels compute, so the convolution units always see constant inputs.
- Sits between the sample source and the next layer.

Parameters:
- NUM_CHANNELS, 4, number of convolution units sequenced.
- WORD_SIZE, 16, fixed-point word width.
- OUT_HEIGHT, 2, words per channel output (input height - kernel height + 1).
- FILL_COUNT, 6, samples needed to fill the kernel window (kernel height * kernel width).
- STRIDE, 2, new samples between successive frames; legal range 1..FILL_COUNT.
- TIMEOUT_CYCLES, 64, watchdog limit in eWAIT; used only with the optional feature.

Ports:
- clk_i  in  1  clock.
- reset_n_i  in  1  asynchronous active-low reset.
- flush_i  in  1  synchronous abort; forces a full refill.
- valid_i  in  1  upstream sample valid.
- data_i  in  WORD_SIZE  upstream sample.
- ready_o  out  1  sample accepted when valid_i & ready_o.
- shift_en_o  out  1  shift strobe to channel shift register, equal to valid_i & ready_o.
- shift_data_o  out  WORD_SIZE  equal to data_i (combinational).
- conv_start_o  out  NUM_CHANNELS  one-cycle start pulse, all bits identical.
- conv_valid_i  in  NUM_CHANNELS  per-channel result valid.
- conv_yumi_o  out  NUM_CHANNELS  per-channel consume.
- conv_data_i  in  NUM_CHANNELS*OUT_HEIGHT*WORD_SIZE  channel results, packed [ch][row][word].
- valid_o  out  1  layer output valid.
- yumi_i  in  1  downstream consume; legal only while valid_o.
- data_o  out  NUM_CHANNELS*OUT_HEIGHT*WORD_SIZE  registered layer output.
- busy_o  out  1  high in eSTART and eWAIT.
- error_o  out  1  sticky watchdog flag.

Behaviour:
- Reset (async, reset_n_i=0) drives the following to 0: valid_o, conv_start_o, conv_yumi_o, data_o, busy_o, error_o, ready_o, shift_en_o.
- Reset also clears the done mask and the sample counter, and sets first_frame=1.
- State is eFILL after reset release, so ready_o=1 the first cycle after release.
- Sample counter width is $clog2(FILL_COUNT+1).
- Target count is FILL_COUNT when first_frame=1, otherwise STRIDE.
- eFILL: ready_o=1; each accepted sample increments the counter.
  - The acceptance that reaches the target clears the counter and first_frame, then goes to eSTART.
- eSTART: lasts exactly one cycle; conv_start_o all ones, ready_o=0, go to eWAIT.
  - Start therefore rises the cycle after the last sample shift.
- eWAIT: ready_o=0.
  - For each channel c with conv_valid_i[c]=1 and done[c]=0: assert conv_yumi_o[c] combinationally that cycle, latch conv_data_i[c] into data_o[c], set done[c].
  - Any number of channels may complete in the same cycle; each receives exactly one yumi.
  - conv_valid_i on an already-done channel is ignored (no yumi).
  - When the done mask is all ones: go to eOUT and clear the mask.
- eOUT: valid_o=1; data_o is stable until the handshake.
  - yumi_i=1 drops valid_o next cycle and returns to eFILL with target STRIDE.
  - No samples are accepted in eOUT.
- flush_i (any state): next state eFILL, first_frame=1, counter=0, done mask=0, valid_o=0, no start issued; data_o keeps its old value.
  - Any channel yumi due in the flush cycle is still issued.
- Overlaps: flush_i has priority over every transition; reset_n_i has priority over flush_i.
- yumi_i outside eOUT is ignored.
- Latency, first frame with back-to-back valid_i: FILL_COUNT accept cycles + 1 start cycle + channel compute time + 1 cycle to eOUT.

Optional Feature:
- Macro: CONV_LAYER_SEQUENCER_TIMEOUT_EN.
- Defined:
  - A wait counter clears on eSTART and increments each cycle in eWAIT.
  - On reaching TIMEOUT_CYCLES with the done mask incomplete: error_o=1 (sticky until reset or flush_i), then behave exactly as flush_i.
- Undefined:
  - No counter logic; error_o tied 0; eWAIT waits indefinitely.

Test Plan:
- Reset, then 6 samples 0x0100..0x0600 back-to-back → ready_o 1 for 6 cycles, then 0.
  - Single conv_start_o=4'b1111 pulse one cycle after the 6th shift.
- All channels assert valid together 5 cycles after start → conv_yumi_o=4'b1111 for one cycle.
  - valid_o rises the next cycle; data_o matches conv_data_i.
- Staggered valid (ch2 at +3, ch0 at +5, ch1/ch3 at +8), yumi_i held 0 for 4 cycles → each yumi fires once.
  - valid_o and data_o stay stable until yumi_i.
  - After yumi_i, exactly 2 samples are accepted before the next start.
- flush_i in eWAIT with done=4'b0101 → no valid_o; next frame requires 6 samples.
- Timeout macro defined, ch3 never valid → error_o=1 at 64 cycles in eWAIT; 6-sample refill required.
- reset_n_i low mid-eWAIT → all outputs 0 immediately (asynchronous); after release, ready_o=1 and 6 samples are required.
